// File: rtl/hack_cpu_exec.sv
// Hack CPU execute/control stage: decode, A/D/PC registers, Hack ALU,
// with instruction-valid and data-read-valid stalling.
module hack_cpu_exec #(
  parameter int ADDR_W = 15,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  input  logic [15:0]       inM,
  input  logic              inM_valid,
  output logic [15:0]       outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic {RUN, WAIT_M} state_t;

  state_t            state, state_nxt;
  logic [15:0]       a_reg, a_nxt, d_reg, d_nxt;
  logic [ADDR_W-1:0] pc_reg, pc_nxt;

  logic is_c, a_sel, zx, nx, zy, ny, f, no, d_a, d_d, d_m, j_lt, j_eq, j_gt;
  assign is_c  = instruction[15];
  assign a_sel = instruction[12];
  assign {zx, nx, zy, ny, f, no} = instruction[11:6];
  assign {d_a, d_d, d_m}         = instruction[5:3];
  assign {j_lt, j_eq, j_gt}      = instruction[2:0];

  logic unused_bits;
  assign unused_bits = ^instruction[14:13];

  logic [15:0] x_op, y_mux, y_op, alu_raw, alu_out;
  logic        zr, ng, taken, exec;

  always_comb begin
    y_mux   = a_sel ? inM : a_reg;
    x_op    = zx ? 16'h0000 : d_reg;
    x_op    = nx ? ~x_op : x_op;
    y_op    = zy ? 16'h0000 : y_mux;
    y_op    = ny ? ~y_op : y_op;
    alu_raw = f ? (x_op + y_op) : (x_op & y_op);
    alu_out = no ? ~alu_raw : alu_raw;
  end

  assign zr    = (alu_out == 16'h0000);
  assign ng    = alu_out[15];
  assign taken = (j_lt & ng) | (j_eq & zr) | (j_gt & ~ng & ~zr);

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    d_nxt     = d_reg;
    pc_nxt    = pc_reg;
    exec      = 1'b0;
    case (state)
      RUN: begin
        if (instr_valid) begin
          if (!is_c) begin
            a_nxt  = instruction;
            pc_nxt = pc_reg + ADDR_W'(1);
          end else if (a_sel && !inM_valid) begin
            state_nxt = WAIT_M;
          end else begin
            exec = 1'b1;
          end
        end
      end
      WAIT_M:  exec = inM_valid;
      default: state_nxt = RUN;
    endcase
    // Jump target uses the A value from before any dA update this cycle.
    if (exec) begin
      if (d_a) a_nxt = alu_out;
      if (d_d) d_nxt = alu_out;
      pc_nxt    = taken ? a_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= PC_RESET;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      d_reg  <= d_nxt;
      pc_reg <= pc_nxt;
    end
  end

  assign outM     = alu_out;
  assign writeM   = exec & d_m & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;

endmodule

// File: tb/tb_hack_cpu_exec.sv
// Bench for hack_cpu_exec: directed scenarios plus random stimulus checked
// against an instruction-level model of the Hack execute stage.
module tb_hack_cpu_exec;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   instruction, inM, outM;
  logic          instr_valid, inM_valid, writeM;
  logic [AW-1:0] addressM, pc;

  int total = 0;
  int bad   = 0;

  logic [15:0]   mA, mD, nA, nD, exp_out, prev_instr;
  logic [AW-1:0] mpc, npc;
  bit            mwait, nwait, exp_w;

  hack_cpu_exec #(.ADDR_W(AW), .PC_RESET('0)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .inM_valid(inM_valid), .outM(outM), .writeM(writeM),
    .addressM(addressM), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = x;
    yy = y;
    if (c[5]) xx = 16'h0000;
    if (c[4]) xx = ~xx;
    if (c[3]) yy = 16'h0000;
    if (c[2]) yy = ~yy;
    r = c[1] ? 16'(xx + yy) : (xx & yy);
    if (c[0]) r = ~r;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, predict this cycle's outputs and next state, compare.
  task automatic drive(input logic [15:0] ins, input logic iv, input logic [15:0] im,
                       input logic imv);
    logic [15:0] r;
    bit ex, zr, ng, tk;
    @(negedge clk);
    instruction = ins; instr_valid = iv; inM = im; inM_valid = imv;
    #1;
    nA = mA; nD = mD; npc = mpc; nwait = mwait; ex = 0; exp_w = 0; exp_out = 16'h0;
    if (!mwait) begin
      if (iv) begin
        if (!ins[15]) begin
          nA  = ins;
          npc = mpc + 15'd1;
        end else if (ins[12] && !imv) nwait = 1;
        else ex = 1;
      end
    end else if (imv) ex = 1;
    if (ex) begin
      r  = alu_f(mD, ins[12] ? im : mA, ins[11:6]);
      zr = (r == 16'h0);
      ng = r[15];
      tk = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
      exp_w   = ins[3];
      exp_out = r;
      if (ins[5]) nA = r;
      if (ins[4]) nD = r;
      npc   = tk ? mA[AW-1:0] : mpc + 15'd1;
      nwait = 0;
    end
    chk("pc", 32'(pc), 32'(mpc));
    chk("addressM", 32'(addressM), 32'(mA[AW-1:0]));
    chk("writeM", 32'(writeM), 32'(exp_w));
    if (exp_w) chk("outM", 32'(outM), 32'(exp_out));
  endtask

  task automatic tick();
    @(posedge clk);
    mA = nA; mD = nD; mpc = npc; mwait = nwait;
    #1;
  endtask

  task automatic step(input logic [15:0] ins, input logic iv = 1'b1,
                      input logic [15:0] im = 16'h0, input logic imv = 1'b0);
    drive(ins, iv, im, imv);
    tick();
  endtask

  task automatic do_reset();
    #3;
    instr_valid = 1'b0; inM_valid = 1'b0;
    reset = 1'b1;
    #1;
    mA = 16'h0; mD = 16'h0; mpc = '0; mwait = 0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_addressM", 32'(addressM), 32'h0);
    chk("rst_writeM", 32'(writeM), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instruction = 16'h0; instr_valid = 1'b0; inM = 16'h0; inM_valid = 1'b0;
    mA = 16'h0; mD = 16'h0; mpc = '0; mwait = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_pc", 32'(pc), 32'h0);
    chk("init_writeM", 32'(writeM), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // A/D load and bubbles
    step(16'h0005);
    chk("lit_a5", 32'(addressM), 32'h5);
    step(16'hEC10);
    chk("lit_pc2", 32'(pc), 32'h2);
    repeat (3) step(16'hEC10, 1'b0);
    chk("lit_bubble_pc", 32'(pc), 32'h2);

    // memory write M=D+1
    step(16'h0064);
    drive(16'hE7C8, 1'b1, 16'h0, 1'b0);
    chk("lit_outM6", 32'(outM), 32'h6);
    chk("lit_writeM1", 32'(writeM), 32'h1);
    chk("lit_addr100", 32'(addressM), 32'd100);
    tick();
    drive(16'h0000, 1'b0, 16'h0, 1'b0);
    chk("lit_writeM0", 32'(writeM), 32'h0);
    chk("lit_pc4", 32'(pc), 32'h4);
    tick();

    // stalled read D=M
    repeat (3) step(16'hFC10, 1'b1, 16'h9999, 1'b0);
    chk("lit_stall_pc", 32'(pc), 32'h4);
    step(16'hFC10, 1'b1, 16'h1234, 1'b1);
    chk("lit_read_pc", 32'(pc), 32'h5);
    drive(16'hE308, 1'b1, 16'h0, 1'b0);
    chk("lit_d1234", 32'(outM), 32'h1234);
    tick();

    // jumps
    step(16'h0005); step(16'hEC10); step(16'h0010);
    step(16'hE301);
    chk("lit_jgt_taken", 32'(pc), 32'h10);
    step(16'h0000); step(16'hEC10); step(16'h0010);
    step(16'hE301);
    chk("lit_jgt_not", 32'(pc), 32'h14);
    step(16'h7FFF); step(16'hEC10); step(16'hE7D0); step(16'h0010);
    step(16'hE304);
    chk("lit_jlt_taken", 32'(pc), 32'h10);

    // PC wrap
    step(16'h7FFF);
    step(16'hEA87);
    chk("lit_jmp7fff", 32'(pc), 32'h7FFF);
    step(16'h0001);
    chk("lit_wrap_pc", 32'(pc), 32'h0);
    chk("lit_wrap_a", 32'(addressM), 32'h1);

    // reset while waiting for inM
    step(16'h0064); step(16'hEC10);
    step(16'hFC10, 1'b1, 16'h0, 1'b0);
    step(16'hFC10, 1'b1, 16'h0, 1'b0);
    do_reset();
    drive(16'hE308, 1'b1, 16'h0, 1'b0);
    chk("lit_rst_d0", 32'(outM), 32'h0);
    chk("lit_rst_w", 32'(writeM), 32'h1);
    tick();

    // random stimulus
    prev_instr = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      if (mwait) ins = prev_instr;
      else if ($urandom_range(0, 1) == 0) ins = {1'b0, 15'($urandom)};
      else ins = {3'b111, 13'($urandom)};
      prev_instr = ins;
      step(ins, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
